// File: rtl/axi_mem_stall_ctrl.sv
// axi_mem_stall_ctrl
// Sequences the IM and DM AXI master ports for the pipeline. Each channel is
// a three-state machine (IDLE -> WAIT -> HOLD). The pipeline is stalled while
// either channel still has an access outstanding. Returned instruction and
// load data are buffered so they stay stable while the other channel finishes.
// A watchdog flags a channel that sits in WAIT for too long.
module axi_mem_stall_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        im_req,
    input  logic        dm_req,
    input  logic [3:0]  dm_web,
    output logic        im_start,
    input  logic        im_done,
    input  logic [31:0] im_rdata,
    output logic        dm_start,
    output logic        dm_write,
    input  logic        dm_done,
    input  logic [31:0] dm_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] ld_data_out,
    output logic        PCstall_axi,
    output logic        DMstall_axi,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ch_state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    ch_state_t        im_state;
    ch_state_t        im_state_next;
    ch_state_t        dm_state;
    ch_state_t        dm_state_next;
    logic             pending_im;
    logic             pending_dm;
    logic             rel;
    logic             im_cap;
    logic             dm_cap;
    logic             any_wait;
    logic             any_done;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_next;

    // Pending/release decode, start pulses and stall outputs; the externally
    // visible pulses and stalls are masked while reset is held.
    always_comb begin
        pending_im  = ((im_state == IDLE) && im_req) || (im_state == WAIT);
        pending_dm  = ((dm_state == IDLE) && dm_req) || (dm_state == WAIT);
        rel         = !pending_im && !pending_dm;
        im_start    = !rst && (im_state == IDLE) && im_req;
        dm_start    = !rst && (dm_state == IDLE) && dm_req;
        PCstall_axi = !rst && (pending_im || pending_dm);
        DMstall_axi = !rst && pending_dm;
        im_cap      = (im_state == WAIT) && im_done;
        dm_cap      = (dm_state == WAIT) && dm_done;
    end

    // Next-state logic for both channels; a done outside WAIT is ignored.
    always_comb begin
        im_state_next = im_state;
        dm_state_next = dm_state;
        case (im_state)
            IDLE:    if (im_req)  im_state_next = WAIT;
            WAIT:    if (im_done) im_state_next = HOLD;
            HOLD:    if (rel)     im_state_next = IDLE;
            default:              im_state_next = IDLE;
        endcase
        case (dm_state)
            IDLE:    if (dm_req)  dm_state_next = WAIT;
            WAIT:    if (dm_done) dm_state_next = HOLD;
            HOLD:    if (rel)     dm_state_next = IDLE;
            default:              dm_state_next = IDLE;
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_state <= IDLE;
            dm_state <= IDLE;
        end else begin
            im_state <= im_state_next;
            dm_state <= dm_state_next;
        end
    end

    // Capture returned data and latch the access direction at start; store
    // completions leave the load buffer untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_out    <= '0;
            ld_data_out <= '0;
            dm_write    <= 1'b0;
        end else begin
            if (im_cap)
                inst_out <= im_rdata;
            if (dm_cap && !dm_write)
                ld_data_out <= dm_rdata;
            if (dm_start)
                dm_write <= (dm_web != 4'b1111);
        end
    end

    // Watchdog counter: counts silent WAIT cycles, clears on any done or when
    // nothing is waiting, saturates at TIMEOUT.
    always_comb begin
        any_wait = (im_state == WAIT) || (dm_state == WAIT);
        any_done = im_done || dm_done;
        if (!any_wait || any_done)
            wd_cnt_next = '0;
        else if (wd_cnt == TIMEOUT_C)
            wd_cnt_next = wd_cnt;
        else
            wd_cnt_next = wd_cnt + 1'b1;
    end

    // Watchdog register and sticky error flag; the FSMs keep waiting after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_next;
            if (wd_cnt_next == TIMEOUT_C)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_mem_stall_ctrl.sv
// Directed testbench for axi_mem_stall_ctrl (TIMEOUT = 16).
module tb_axi_mem_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req;
    logic        dm_req;
    logic [3:0]  dm_web;
    logic        im_start;
    logic        im_done;
    logic [31:0] im_rdata;
    logic        dm_start;
    logic        dm_write;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic [31:0] inst_out;
    logic [31:0] ld_data_out;
    logic        PCstall_axi;
    logic        DMstall_axi;
    logic        timeout_err;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] inst_model;
    logic [31:0] ld_model;

    axi_mem_stall_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .dm_req(dm_req), .dm_web(dm_web),
        .im_start(im_start), .im_done(im_done), .im_rdata(im_rdata),
        .dm_start(dm_start), .dm_write(dm_write), .dm_done(dm_done),
        .dm_rdata(dm_rdata), .inst_out(inst_out), .ld_data_out(ld_data_out),
        .PCstall_axi(PCstall_axi), .DMstall_axi(DMstall_axi),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One access group: both requested channels start in cycle 0, IM done in
    // cycle kim, DM done in cycle kdm, release in cycle max(k)+1.
    task automatic txn(input string tag, input logic im, input logic dm,
                       input logic [3:0] web, input int kim, input int kdm,
                       input logic [31:0] ird, input logic [31:0] drd);
        int kmax;
        kmax = 0;
        if (im) kmax = kim;
        if (dm && kdm > kmax) kmax = kdm;
        im_req = im;
        dm_req = dm;
        dm_web = web;
        for (int c = 0; c <= kmax + 1; c++) begin
            im_done  = im && (c == kim);
            dm_done  = dm && (c == kdm);
            im_rdata = ird;
            dm_rdata = drd;
            #1;
            check_val($sformatf("%s_pcstall_c%0d", tag, c), PCstall_axi, c <= kmax);
            check_val($sformatf("%s_dmstall_c%0d", tag, c), DMstall_axi, dm && (c <= kdm));
            check_val($sformatf("%s_imstart_c%0d", tag, c), im_start, im && (c == 0));
            check_val($sformatf("%s_dmstart_c%0d", tag, c), dm_start, dm && (c == 0));
            if (dm && c == 1)
                check_val({tag, "_dmwrite"}, dm_write, web != 4'b1111);
            step();
        end
        im_done = 1'b0;
        dm_done = 1'b0;
        if (im) inst_model = ird;
        if (dm && web == 4'b1111) ld_model = drd;
        check_val({tag, "_inst"}, inst_out, inst_model);
        check_val({tag, "_ld"}, ld_data_out, ld_model);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; im_req = 1'b1; dm_req = 1'b1; dm_web = 4'b1111;
        im_done = 1'b0; dm_done = 1'b0; im_rdata = '0; dm_rdata = '0;
        inst_model = '0; ld_model = '0;
        step();
        #1;
        check_val("rst_imstart", im_start, 1'b0);
        check_val("rst_dmstart", dm_start, 1'b0);
        check_val("rst_pcstall", PCstall_axi, 1'b0);
        check_val("rst_dmstall", DMstall_axi, 1'b0);
        check_val("rst_inst", inst_out, 32'h0);
        check_val("rst_ld", ld_data_out, 32'h0);
        check_val("rst_dmwrite", dm_write, 1'b0);
        check_val("rst_terr", timeout_err, 1'b0);
        step();
        rst = 1'b0;

        txn("fetch", 1'b1, 1'b0, 4'b1111, 3, 0, 32'h00500093, 32'h0);
        txn("load", 1'b1, 1'b1, 4'b1111, 2, 6, 32'h00000013, 32'hDEADBEEF);
        txn("ld1234", 1'b1, 1'b1, 4'b1111, 1, 1, 32'h00000033, 32'h00001234);
        txn("store", 1'b1, 1'b1, 4'b1100, 2, 3, 32'h00000093, 32'hFFFFFFFF);

        // Spurious done pulses with both channels idle.
        im_req = 1'b0; dm_req = 1'b0;
        im_done = 1'b1; im_rdata = 32'hBADBAD00;
        dm_done = 1'b1; dm_rdata = 32'hBADBAD11;
        #1;
        check_val("spur_pcstall", PCstall_axi, 1'b0);
        check_val("spur_imstart", im_start, 1'b0);
        step();
        im_done = 1'b0; dm_done = 1'b0;
        #1;
        check_val("spur_inst", inst_out, inst_model);
        check_val("spur_ld", ld_data_out, ld_model);
        check_val("spur_pcstall2", PCstall_axi, 1'b0);
        step();
        txn("after_spur", 1'b1, 1'b0, 4'b1111, 1, 0, 32'h00100113, 32'h0);

        // Watchdog: DM load with done withheld; WAIT entered in cycle 1.
        im_req = 1'b0; dm_req = 1'b1; dm_web = 4'b1111;
        for (int c = 0; c <= 21; c++) begin
            dm_done  = (c == 20);
            dm_rdata = 32'hCAFEF00D;
            #1;
            check_val($sformatf("wd_terr_c%0d", c), timeout_err, c >= 17);
            check_val($sformatf("wd_pcstall_c%0d", c), PCstall_axi, c <= 20);
            step();
        end
        dm_done = 1'b0;
        ld_model = 32'hCAFEF00D;
        check_val("wd_ld", ld_data_out, ld_model);
        check_val("wd_terr_sticky", timeout_err, 1'b1);

        // Reset while both channels wait.
        im_req = 1'b1; dm_req = 1'b1; dm_web = 4'b1111;
        step();
        step();
        #1;
        check_val("mid_pcstall_pre", PCstall_axi, 1'b1);
        rst = 1'b1;
        #1;
        check_val("mid_pcstall", PCstall_axi, 1'b0);
        check_val("mid_dmstall", DMstall_axi, 1'b0);
        check_val("mid_imstart", im_start, 1'b0);
        check_val("mid_dmstart", dm_start, 1'b0);
        check_val("mid_terr", timeout_err, 1'b0);
        check_val("mid_inst", inst_out, 32'h0);
        step();
        #1;
        check_val("mid_imstart_held", im_start, 1'b0);
        rst = 1'b0;
        inst_model = '0;
        ld_model = '0;
        txn("post_rst", 1'b1, 1'b1, 4'b1111, 2, 2, 32'h00208233, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
